// File: rtl/mac_window_if.sv
// Operand-in / result-out handshake bundle for mac_window_ctrl.
// The slave modport is the block's view; the master modport is the view of whoever drives it.
interface mac_window_if #(
    parameter int W_WIDTH   = 8,
    parameter int A_WIDTH   = 8,
    parameter int OUT_WIDTH = 8,
    parameter int CNT_WIDTH = 10
);
    logic                        in_valid;
    logic                        in_ready;
    logic signed [W_WIDTH-1:0]   in_w;
    logic        [A_WIDTH-1:0]   in_a;
    logic                        in_last;
    logic                        out_valid;
    logic                        out_ready;
    logic signed [OUT_WIDTH-1:0] out_data;
    logic                        out_sat;
    logic        [CNT_WIDTH-1:0] out_len;

    modport slave (
        input  in_valid, in_w, in_a, in_last, out_ready,
        output in_ready, out_valid, out_data, out_sat, out_len
    );

    modport master (
        output in_valid, in_w, in_a, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_sat, out_len
    );
endinterface

// File: rtl/mac_window_ctrl.sv
// Window controller for a 2-stage MAC: gates operand beats onto the MAC, drives accu_rst,
// captures each window sum and emits it rounded, shifted and saturated.
module mac_window_ctrl #(
    parameter int W_WIDTH    = 8,
    parameter int A_WIDTH    = 8,
    parameter int PLUS_WIDTH = 4,
    parameter int OUT_WIDTH  = 8,
    parameter int CNT_WIDTH  = 10
) (
    input  logic                                          clk,
    input  logic                                          rst,
    mac_window_if.slave                                   bus,
    input  logic        [4:0]                             cfg_shift,
    output logic signed [W_WIDTH-1:0]                     mac_w,
    output logic        [A_WIDTH-1:0]                     mac_a,
    output logic                                          mac_accu_rst,
    input  logic signed [W_WIDTH+A_WIDTH+PLUS_WIDTH-1:0]  mac_z
);
    localparam int Z_WIDTH = W_WIDTH + A_WIDTH + PLUS_WIDTH;
    localparam int R_WIDTH = Z_WIDTH + 1;
    localparam logic signed [R_WIDTH-1:0] SAT_MAX = R_WIDTH'(2 ** (OUT_WIDTH - 1) - 1);
    localparam logic signed [R_WIDTH-1:0] SAT_MIN = R_WIDTH'(-(2 ** (OUT_WIDTH - 1)));

    typedef enum logic [1:0] {
        S_INIT,
        S_ACCUM,
        S_DRAIN1,
        S_DRAIN2
    } state_t;

    state_t                      r_state;
    state_t                      w_state_next;
    logic                        w_in_ready;
    logic                        w_accept;
    logic                        w_capture;
    logic                        w_accu_rst;

    logic        [CNT_WIDTH-1:0] r_count;
    logic                        r_out_valid;
    logic signed [OUT_WIDTH-1:0] r_out_data;
    logic                        r_out_sat;
    logic        [CNT_WIDTH-1:0] r_out_len;

    logic signed [R_WIDTH-1:0]   w_z_ext;
    logic signed [R_WIDTH-1:0]   w_round;
    logic signed [R_WIDTH-1:0]   w_rounded;
    logic signed [R_WIDTH-1:0]   w_shifted;
    logic signed [OUT_WIDTH-1:0] w_q_data;
    logic                        w_q_sat;

    // NOTE: registers take <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_INIT;
        else     r_state <= w_state_next;
    end

    // NOTE: every signal written here gets a default first; a path leaving one unassigned infers a latch.
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_accu_rst   = 1'b0;
        unique case (r_state)
            S_INIT: begin
                w_accu_rst   = 1'b1;
                w_state_next = S_ACCUM;
            end
            S_ACCUM: begin
                w_in_ready = 1'b1;
                w_accept   = bus.in_valid;
                if (bus.in_valid && bus.in_last) w_state_next = S_DRAIN1;
            end
            // Bubble cycle: keeps a next-window product out of a sum that accu_rst is about to clear.
            S_DRAIN1: w_state_next = S_DRAIN2;
            S_DRAIN2: begin
                w_capture = !r_out_valid || bus.out_ready;
                if (w_capture) begin
                    w_accu_rst   = 1'b1;
                    w_state_next = S_ACCUM;
                end
            end
            default: w_state_next = S_INIT;
        endcase
    end

    assign bus.in_ready  = w_in_ready;
    assign mac_w         = w_accept ? bus.in_w : '0;
    assign mac_a         = w_accept ? bus.in_a : '0;
    assign mac_accu_rst  = w_accu_rst;

    // Round half up, then arithmetic shift; one extra bit keeps the rounding add from overflowing.
    always_comb begin
        w_z_ext   = {mac_z[Z_WIDTH-1], mac_z};
        w_round   = (cfg_shift == 5'd0) ? '0 : (R_WIDTH'(1) << (cfg_shift - 5'd1));
        w_rounded = w_z_ext + w_round;
        w_shifted = w_rounded >>> cfg_shift;
        w_q_data  = w_shifted[OUT_WIDTH-1:0];
        w_q_sat   = 1'b0;
        if (w_shifted > SAT_MAX) begin
            w_q_data = SAT_MAX[OUT_WIDTH-1:0];
            w_q_sat  = 1'b1;
        end else if (w_shifted < SAT_MIN) begin
            w_q_data = SAT_MIN[OUT_WIDTH-1:0];
            w_q_sat  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
            r_out_len   <= '0;
        end else begin
            if (w_capture)                      r_count <= '0;
            else if (w_accept && !(&r_count))   r_count <= r_count + 1'b1;

            if (w_capture) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_q_data;
                r_out_sat   <= w_q_sat;
                r_out_len   <= r_count;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_sat   = r_out_sat;
    assign bus.out_len   = r_out_len;
endmodule

// File: tb/tb_mac_window_ctrl.sv
// Self-checking bench for mac_window_ctrl: directed windows plus random windows against a window-level model.
module tb_mac_window_ctrl;
    localparam int W_WIDTH    = 8;
    localparam int A_WIDTH    = 8;
    localparam int PLUS_WIDTH = 4;
    localparam int OUT_WIDTH  = 8;
    localparam int CNT_WIDTH  = 10;
    localparam int Z_WIDTH    = W_WIDTH + A_WIDTH + PLUS_WIDTH;
    localparam longint OUT_MAX = 2 ** (OUT_WIDTH - 1) - 1;
    localparam longint OUT_MIN = -(2 ** (OUT_WIDTH - 1));
    localparam longint LEN_MAX = 2 ** CNT_WIDTH - 1;

    typedef struct {
        longint data;
        longint sat;
        longint len;
    } res_t;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [4:0]                cfg_shift;
    logic signed [W_WIDTH-1:0] mac_w;
    logic [A_WIDTH-1:0]        mac_a;
    logic                      mac_accu_rst;
    logic signed [Z_WIDTH-1:0] mac_z;
    logic signed [15:0]        mac_p;

    int     n_checks = 0;
    int     n_fail   = 0;
    int     rdy_pct  = 100;
    res_t   exp_q[$];
    res_t   seen_q[$];
    longint win_sum  = 0;
    int     win_len  = 0;

    mac_window_if #(.W_WIDTH(W_WIDTH), .A_WIDTH(A_WIDTH), .OUT_WIDTH(OUT_WIDTH), .CNT_WIDTH(CNT_WIDTH)) bus ();

    mac_window_ctrl #(
        .W_WIDTH(W_WIDTH), .A_WIDTH(A_WIDTH), .PLUS_WIDTH(PLUS_WIDTH),
        .OUT_WIDTH(OUT_WIDTH), .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .cfg_shift(cfg_shift),
        .mac_w(mac_w), .mac_a(mac_a), .mac_accu_rst(mac_accu_rst), .mac_z(mac_z)
    );

    always #5 clk = ~clk;

    // Conventional 2-stage MAC the block controls: product register, then accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mac_p <= '0;
            mac_z <= '0;
        end else begin
            mac_p <= 16'(mac_w) * 16'($signed({1'b0, mac_a}));
            mac_z <= mac_accu_rst ? '0 : mac_z + Z_WIDTH'(mac_p);
        end
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Window result straight from the arithmetic rules: round half up, divide, clamp.
    function automatic res_t model(input longint sum, input int shift, input int len);
        res_t   r;
        longint v;
        v      = longint'($floor(real'(sum) / (2.0 ** shift) + 0.5));
        r.data = v;
        r.sat  = 0;
        if (v > OUT_MAX) begin
            r.data = OUT_MAX;
            r.sat  = 1;
        end else if (v < OUT_MIN) begin
            r.data = OUT_MIN;
            r.sat  = 1;
        end
        r.len = (len > LEN_MAX) ? LEN_MAX : len;
        return r;
    endfunction

    // Entered and left at posedge+1; stall counts cycles the beat waited with in_ready low.
    task automatic send_beat(input int w, input int a, input bit last, output int stall);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_w     = W_WIDTH'(w);
        bus.in_a     = A_WIDTH'(a);
        bus.in_last  = last;
        forever begin
            @(negedge clk);
            if (bus.in_ready) begin
                check("pass_w", mac_w, w);
                check("pass_a", mac_a, a);
                break;
            end
            check("gate_w", mac_w, 0);
            check("gate_a", mac_a, 0);
            n++;
            if (n >= 500) begin
                check("in_ready_timeout", n, 0);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        win_sum += longint'(w) * longint'(a);
        win_len++;
        if (last) begin
            exp_q.push_back(model(win_sum, int'(cfg_shift), win_len));
            win_sum = 0;
            win_len = 0;
        end
        stall = n;
    endtask

    task automatic send_rep(input int w, input int a, input int n, output int first_stall);
        int s;
        first_stall = 0;
        for (int i = 0; i < n; i++) begin
            send_beat(w, a, (i == n - 1), s);
            if (i == 0) first_stall = s;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Counts negedges until out_valid is seen; leaves the bench at that negedge.
    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 100);
        if (!bus.out_valid) check("valid_timeout", 0, 1);
    endtask

    task automatic wait_seen(input int target);
        int n;
        n = 0;
        while (seen_q.size() < target && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (seen_q.size() < target) check("seen_timeout", seen_q.size(), target);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin : ready_drv
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = ($urandom_range(0, 99) < rdy_pct);
        end
    end

    // Scoreboard: every handshake is compared with the oldest expected window; stalled results must hold.
    initial begin : monitor
        res_t   e;
        res_t   s;
        bit     held;
        longint h_data;
        longint h_sat;
        longint h_len;
        held = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    check("hold_valid", bus.out_valid, 1);
                    check("hold_data", bus.out_data, h_data);
                    check("hold_sat", bus.out_sat, h_sat);
                    check("hold_len", bus.out_len, h_len);
                end
                if (bus.out_valid && bus.out_ready) begin
                    s.data = bus.out_data;
                    s.sat  = bus.out_sat;
                    s.len  = bus.out_len;
                    seen_q.push_back(s);
                    if (exp_q.size() == 0) begin
                        check("out_unexpected", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", s.data, e.data);
                        check("out_sat", s.sat, e.sat);
                        check("out_len", s.len, e.len);
                    end
                end
                held   = bus.out_valid && !bus.out_ready;
                h_data = bus.out_data;
                h_sat  = bus.out_sat;
                h_len  = bus.out_len;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int s;
        int n;
        int base;
        int len;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_w     = '0;
        bus.in_a     = '0;
        bus.in_last  = 1'b0;
        cfg_shift    = 5'd0;
        #2 rst = 1'b1;
        idle(2);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_sat", bus.out_sat, 0);
        check("rst_out_len", bus.out_len, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_accu_rst", mac_accu_rst, 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("init_in_ready", bus.in_ready, 0);
        check("init_accu_rst", mac_accu_rst, 1);
        @(posedge clk);
        #1;
        check("accum_in_ready", bus.in_ready, 1);
        check("accum_accu_rst", mac_accu_rst, 0);

        // Four beats of 3*10, no shift: 120 is in range.
        send_rep(3, 10, 4, s);
        wait_valid(n);
        check("t1_latency", n, 3);
        check("t1_data", bus.out_data, 120);
        check("t1_sat", bus.out_sat, 0);
        check("t1_len", bus.out_len, 4);
        @(posedge clk); #1;

        send_rep(127, 255, 1, s);
        wait_valid(n);
        check("sat_hi_data", bus.out_data, 127);
        check("sat_hi_flag", bus.out_sat, 1);
        @(posedge clk); #1;

        send_rep(-128, 255, 1, s);
        wait_valid(n);
        check("sat_lo_data", bus.out_data, -128);
        check("sat_lo_flag", bus.out_sat, 1);
        @(posedge clk); #1;

        cfg_shift = 5'd2;
        send_rep(-2, 5, 3, s);
        wait_valid(n);
        check("t2_data", bus.out_data, -7);
        check("t2_sat", bus.out_sat, 0);
        check("t2_len", bus.out_len, 3);
        @(posedge clk); #1;

        cfg_shift = 5'd8;
        send_rep(-128, 255, 1, s);
        wait_valid(n);
        check("t5_data", bus.out_data, -127);
        check("t5_sat", bus.out_sat, 0);
        check("t5_len", bus.out_len, 1);
        @(posedge clk); #1;

        // Back-to-back windows with in_valid held high.
        cfg_shift = 5'd0;
        base = seen_q.size();
        send_rep(1, 1, 2, s);
        send_rep(2, 2, 1, s);
        check("t3_bubble_a", s, 2);
        send_rep(1, 1, 2, s);
        check("t3_bubble_b", s, 2);
        wait_seen(base + 3);
        check("t3_sum0", seen_q[base].data, 2);
        check("t3_sum1", seen_q[base + 1].data, 4);
        check("t3_sum2", seen_q[base + 2].data, 2);

        // Downstream stalled: second window must wait in DRAIN2 behind the held first result.
        rdy_pct = 0;
        idle(2);
        base = seen_q.size();
        send_rep(5, 3, 2, s);
        send_rep(-1, 7, 3, s);
        idle(4);
        @(negedge clk);
        check("t4_held_valid", bus.out_valid, 1);
        check("t4_held_data", bus.out_data, 30);
        check("t4_stall_ready", bus.in_ready, 0);
        check("t4_stall_accu", mac_accu_rst, 0);
        @(posedge clk); #1;
        rdy_pct = 100;
        wait_seen(base + 2);
        check("t4_first", seen_q[base].data, 30);
        check("t4_second", seen_q[base + 1].data, -21);

        // Reset in the middle of a window while a result is pending.
        rdy_pct = 0;
        idle(2);
        send_rep(1, 1, 1, s);
        idle(4);
        check("t6_pending", bus.out_valid, 1);
        for (int i = 0; i < 3; i++) send_beat(9, 9, 1'b0, s);
        rst = 1'b1;
        #1;
        check("t6_rst_valid", bus.out_valid, 0);
        check("t6_rst_accu", mac_accu_rst, 1);
        check("t6_rst_ready", bus.in_ready, 0);
        exp_q.delete();
        win_sum = 0;
        win_len = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        rdy_pct = 100;
        base = seen_q.size();
        send_rep(4, 4, 2, s);
        wait_seen(base + 1);
        check("t6_new_sum", seen_q[base].data, 32);
        check("t6_new_len", seen_q[base].len, 2);

        // Beat count saturates while the sum keeps accumulating.
        base = seen_q.size();
        send_beat(1, 1, 1'b0, s);
        for (int i = 0; i < 1029; i++) send_beat(0, int'($urandom_range(0, 255)), (i == 1028), s);
        wait_seen(base + 1);
        check("cnt_sat_len", seen_q[base].len, LEN_MAX);
        check("cnt_sat_data", seen_q[base].data, 1);

        // Random windows, gaps and downstream back-pressure; shift changes only between drained batches.
        for (int b = 0; b < 4; b++) begin
            cfg_shift = 5'($urandom_range(0, Z_WIDTH - 1));
            rdy_pct   = 30 + 20 * b;
            for (int w = 0; w < 12; w++) begin
                len = int'($urandom_range(1, 16));
                for (int k = 0; k < len; k++) begin
                    if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
                    send_beat(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)), (k == len - 1), s);
                end
            end
            drain();
        end

        rdy_pct = 100;
        drain();
        check("final_queue", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end
endmodule
